// File: rtl/loop_buffer_sync_paged.sv
`default_nettype none
// ============================================================================
// Module   : loop_buffer_sync_paged
// Purpose  : Single-clock multi-page loop buffer; producer fills and commits
//            pages, consumer random-reads and releases the head page.
//            Define LOOP_BUF_STAT_EN to add peak_used / drop_cnt statistics.
// Revision : 1.0 - initial release
// ============================================================================
module loop_buffer_sync_paged #(
    parameter int DATA_W     = 64,
    parameter int PAGE_AW    = 4,
    parameter int PAGE_NUM_W = 3,
    parameter int INFO_W     = 32,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_wen,
    input  logic [PAGE_AW-1:0]    wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_wlast,
    input  logic [INFO_W-1:0]     wr_info,
    output logic                  wr_rdy,
    output logic [PAGE_NUM_W:0]   free_size,
    input  logic                  rd_ren,
    input  logic [PAGE_AW-1:0]    rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_data_vld,
    output logic                  rd_vld,
    output logic [INFO_W-1:0]     rd_info,
    input  logic                  rd_rdy,
`ifdef LOOP_BUF_STAT_EN
    output logic [PAGE_NUM_W:0]   peak_used,
    output logic [15:0]           drop_cnt,
`endif
    input  logic                  err_clr,
    output logic                  ovf_err,
    output logic                  udf_err
);

    localparam int                  c_PAGE_CNT  = 1 << PAGE_NUM_W;
    localparam int                  c_MEM_DEPTH = 1 << (PAGE_NUM_W + PAGE_AW);
    localparam logic [PAGE_NUM_W:0] c_ONE       = 1;
    localparam logic [PAGE_NUM_W:0] c_PAGES     = c_ONE << PAGE_NUM_W;

    logic [DATA_W-1:0]     r_mem [c_MEM_DEPTH];
    logic [INFO_W-1:0]     r_info [c_PAGE_CNT];
    logic [PAGE_NUM_W-1:0] r_wbadr;
    logic [PAGE_NUM_W-1:0] r_rbadr;
    logic [PAGE_NUM_W:0]   r_used;
    logic                  r_ovf;
    logic                  r_udf;
    logic [DATA_W-1:0]     r_rd_q;
    logic                  r_vld1;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_commit;
    logic                  w_release;
    logic [PAGE_NUM_W:0]   w_used_nxt;

    // Full/empty come from the pre-cycle count, so a same-cycle release never rescues a commit
    assign w_full    = (r_used == c_PAGES);
    assign w_empty   = (r_used == '0);
    assign w_commit  = wr_wlast & ~w_full;
    assign w_release = rd_rdy & ~w_empty;

    always_comb begin
        w_used_nxt = r_used;
        if (w_commit && !w_release)
            w_used_nxt = r_used + c_ONE;
        else if (!w_commit && w_release)
            w_used_nxt = r_used - c_ONE;
    end

    assign wr_rdy    = ~w_full;
    assign free_size = c_PAGES - r_used;
    assign rd_vld    = ~w_empty;
    assign rd_info   = r_info[r_rbadr];
    assign ovf_err   = r_ovf;
    assign udf_err   = r_udf;

    // RAM contents survive reset; writes while full would land on the head page
    always_ff @(posedge clk) begin
        if (wr_wen && !w_full)
            r_mem[{r_wbadr, wr_addr}] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbadr <= '0;
            r_rbadr <= '0;
            r_used  <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            for (int i = 0; i < c_PAGE_CNT; i++)
                r_info[i] <= '0;
        end else begin
            r_used <= w_used_nxt;
            if (w_commit) begin
                r_info[r_wbadr] <= wr_info;
                r_wbadr         <= r_wbadr + PAGE_NUM_W'(1);
            end
            if (w_release)
                r_rbadr <= r_rbadr + PAGE_NUM_W'(1);
            if (wr_wlast && w_full)
                r_ovf <= 1'b1;
            else if (err_clr)
                r_ovf <= 1'b0;
            if (rd_rdy && w_empty)
                r_udf <= 1'b1;
            else if (err_clr)
                r_udf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_q <= '0;
            r_vld1 <= 1'b0;
        end else begin
            r_vld1 <= rd_ren;
            if (rd_ren)
                r_rd_q <= r_mem[{r_rbadr, rd_addr}];
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] r_rd_q2;
            logic              r_vld2;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_q2 <= '0;
                    r_vld2  <= 1'b0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1)
                        r_rd_q2 <= r_rd_q;
                end
            end
            assign rd_data     = r_rd_q2;
            assign rd_data_vld = r_vld2;
        end else begin : g_lat1
            assign rd_data     = r_rd_q;
            assign rd_data_vld = r_vld1;
        end
    endgenerate

`ifdef LOOP_BUF_STAT_EN
    logic [PAGE_NUM_W:0] r_peak;
    logic [15:0]         r_drop;
    logic [PAGE_NUM_W:0] w_peak_base;
    logic [15:0]         w_drop_base;

    // A clear restarts tracking from the current cycle; a same-cycle drop still counts
    assign w_peak_base = err_clr ? '0 : r_peak;
    assign w_drop_base = err_clr ? '0 : r_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_peak <= '0;
            r_drop <= '0;
        end else begin
            r_peak <= (w_used_nxt > w_peak_base) ? w_used_nxt : w_peak_base;
            if (wr_wlast && w_full && (w_drop_base != 16'hFFFF))
                r_drop <= w_drop_base + 16'd1;
            else
                r_drop <= w_drop_base;
        end
    end

    assign peak_used = r_peak;
    assign drop_cnt  = r_drop;
`endif

endmodule
`default_nettype wire
